// File: rtl/sar_search_ctrl_if.sv
// Handshake bundle between the SAR search controller and its environment
// (start request, comparator flags in, trial/result/status out).
interface sar_search_ctrl_if #(
    parameter int WIDTH = 4
);
    localparam int SW = $clog2(WIDTH) + 1;

    logic             start;
    logic             aeqb;
    logic             agtb;
    logic             altb;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic             found;
    logic             error;
    logic [WIDTH-1:0] result;
    logic [SW-1:0]    steps;

    // Controller side: consumes start and comparator flags, drives trial and status.
    modport master (
        input  start, aeqb, agtb, altb,
        output trial, busy, done, found, error, result, steps
    );

    // Environment side: requester plus the comparator that sees trial on its B input.
    modport slave (
        output start, aeqb, agtb, altb,
        input  trial, busy, done, found, error, result, steps
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search over an external magnitude comparator, one probe per clock.
// Optional feature: define SAR_SEARCH_EARLY_EXIT_EN to stop on the first aeqb probe.
module sar_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sar_search_ctrl_if.master     sar
);
    localparam int SW = $clog2(WIDTH) + 1;
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [WIDTH-1:0] MSB_TRIAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [KW-1:0]    K_START   = KW'(WIDTH - 1);
    localparam logic [KW-1:0]    K_ONE     = KW'(1);
    localparam logic [SW-1:0]    STEP_ONE  = SW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] trial_q, trial_n;
    logic [WIDTH-1:0] result_q, result_n;
    logic [KW-1:0]    k_q, k_n;
    logic [SW-1:0]    steps_q, steps_n;
    logic             found_q, found_n;
    logic             error_q, error_n;
    logic             done_q, done_n;
    logic [WIDTH-1:0] probe_next;
    logic             flags_onehot;

    assign flags_onehot = ( sar.aeqb & ~sar.agtb & ~sar.altb) |
                          (~sar.aeqb &  sar.agtb & ~sar.altb) |
                          (~sar.aeqb & ~sar.agtb &  sar.altb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            result_q <= '0;
            k_q      <= '0;
            steps_q  <= '0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            trial_q  <= trial_n;
            result_q <= result_n;
            k_q      <= k_n;
            steps_q  <= steps_n;
            found_q  <= found_n;
            error_q  <= error_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        trial_n    = trial_q;
        result_n   = result_q;
        k_n        = k_q;
        steps_n    = steps_q;
        found_n    = found_q;
        error_n    = error_q;
        done_n     = 1'b0;
        probe_next = trial_q;

        unique case (state_q)
            IDLE: begin
                if (sar.start) begin
                    trial_n = MSB_TRIAL;
                    k_n     = K_START;
                    steps_n = '0;
                    found_n = 1'b0;
                    error_n = 1'b0;
                    state_n = PROBE;
                end
            end

            PROBE: begin
                steps_n = steps_q + STEP_ONE;
                if (!flags_onehot) begin
                    error_n  = 1'b1;
                    found_n  = 1'b0;
                    result_n = trial_q;
                    done_n   = 1'b1;
                    state_n  = IDLE;
                end
`ifdef SAR_SEARCH_EARLY_EXIT_EN
                else if (sar.aeqb) begin
                    result_n = trial_q;
                    found_n  = 1'b1;
                    done_n   = 1'b1;
                    state_n  = IDLE;
                end
`endif
                else begin
                    // A below the trial means bit k overshoots; equality keeps it (A >= trial).
                    if (sar.altb) begin
                        probe_next[k_q] = 1'b0;
                    end
                    if (k_q == '0) begin
                        result_n = probe_next;
                        found_n  = 1'b1;
                        done_n   = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        trial_n              = probe_next;
                        trial_n[k_q - K_ONE] = 1'b1;
                        k_n                  = k_q - K_ONE;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign sar.trial  = trial_q;
    assign sar.busy   = (state_q == PROBE);
    assign sar.done   = done_q;
    assign sar.found  = found_q;
    assign sar.error  = error_q;
    assign sar.result = result_q;
    assign sar.steps  = steps_q;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl: vector table of searches plus reset/error/start corner sequences.
module tb_sar_search_ctrl;
    localparam int WIDTH = 4;
`ifdef SAR_SEARCH_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  exp_result;
        int          steps_full;
        int          steps_ee;
        logic [15:0] tseq;
    } vec_t;

    logic clk;
    logic rst_n;
    logic [3:0] a_val;
    logic bad;
    int tests;
    int failed;
    logic [3:0] trials[8];
    int n_trials;
    int nv;
    int exp_steps;
    logic to;
    vec_t vecs[8];

    sar_search_ctrl_if #(.WIDTH(WIDTH)) sar ();

    sar_search_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sar   (sar.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational comparator model, with a forced illegal flag pattern on demand.
    always_comb begin
        if (bad) begin
            sar.aeqb = 1'b1;
            sar.agtb = 1'b1;
            sar.altb = 1'b0;
        end else begin
            sar.aeqb = (a_val == sar.trial);
            sar.agtb = (a_val >  sar.trial);
            sar.altb = (a_val <  sar.trial);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_search(input logic [3:0] a, output logic timeout);
        int guard;
        a_val = a;
        n_trials = 0;
        timeout = 1'b0;
        guard = 0;
        sar.start = 1'b1;
        @(posedge clk); #1;
        sar.start = 1'b0;
        while (!sar.done && guard < 20) begin
            if (sar.busy && n_trials < 8) begin
                trials[n_trials] = sar.trial;
                n_trials++;
            end
            @(posedge clk); #1;
            guard++;
        end
        if (!sar.done) timeout = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_trial"},  32'(sar.trial),  32'd0);
        check({tag, "_busy"},   32'(sar.busy),   32'd0);
        check({tag, "_done"},   32'(sar.done),   32'd0);
        check({tag, "_found"},  32'(sar.found),  32'd0);
        check({tag, "_error"},  32'(sar.error),  32'd0);
        check({tag, "_result"}, 32'(sar.result), 32'd0);
        check({tag, "_steps"},  32'(sar.steps),  32'd0);
    endtask

    initial begin
        tests = 0;
        failed = 0;
        a_val = 4'd0;
        bad = 1'b0;
        sar.start = 1'b0;
        rst_n = 1'b0;

        //                a      result steps_full steps_ee tseq {t0,t1,t2,t3}
        vecs[0] = '{4'd5,  4'd5,  4, 4, 16'h8465};
        vecs[1] = '{4'd8,  4'd8,  4, 1, 16'h8CA9};
        vecs[2] = '{4'd0,  4'd0,  4, 4, 16'h8421};
        vecs[3] = '{4'd15, 4'd15, 4, 4, 16'h8CEF};
        vecs[4] = '{4'd10, 4'd10, 4, 3, 16'h8CAB};
        vecs[5] = '{4'd3,  4'd3,  4, 4, 16'h8423};
        vecs[6] = '{4'd12, 4'd12, 4, 2, 16'h8CED};
        vecs[7] = '{4'd7,  4'd7,  4, 4, 16'h8467};
        nv = 8;

        #3;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < nv; i++) begin
            exp_steps = EE ? vecs[i].steps_ee : vecs[i].steps_full;
            do_search(vecs[i].a, to);
            check($sformatf("timeout_a%0d", vecs[i].a), 32'(to), 32'd0);
            check($sformatf("result_a%0d", vecs[i].a), 32'(sar.result), 32'(vecs[i].exp_result));
            check($sformatf("found_a%0d", vecs[i].a), 32'(sar.found), 32'd1);
            check($sformatf("error_a%0d", vecs[i].a), 32'(sar.error), 32'd0);
            check($sformatf("steps_a%0d", vecs[i].a), 32'(sar.steps), 32'(exp_steps));
            check($sformatf("busy_at_done_a%0d", vecs[i].a), 32'(sar.busy), 32'd0);
            check($sformatf("ntrials_a%0d", vecs[i].a), 32'(n_trials), 32'(exp_steps));
            for (int j = 0; j < exp_steps && j < n_trials; j++) begin
                check($sformatf("trial%0d_a%0d", j, vecs[i].a), 32'(trials[j]),
                      32'(vecs[i].tseq[15 - 4*j -: 4]));
            end
            @(posedge clk); #1;
            check($sformatf("done_width_a%0d", vecs[i].a), 32'(sar.done), 32'd0);
            check($sformatf("result_hold_a%0d", vecs[i].a), 32'(sar.result), 32'(vecs[i].exp_result));
        end

        // Illegal flags (aeqb & agtb) on the second probe, where trial is 4.
        a_val = 4'd5;
        sar.start = 1'b1;
        @(posedge clk); #1;
        sar.start = 1'b0;
        @(posedge clk); #1;
        bad = 1'b1;
        @(posedge clk); #1;
        bad = 1'b0;
        check("err_done",   32'(sar.done),   32'd1);
        check("err_error",  32'(sar.error),  32'd1);
        check("err_found",  32'(sar.found),  32'd0);
        check("err_steps",  32'(sar.steps),  32'd2);
        check("err_result", 32'(sar.result), 32'd4);
        check("err_busy",   32'(sar.busy),   32'd0);
        @(posedge clk); #1;
        check("err_done_low", 32'(sar.done),  32'd0);
        check("err_hold",     32'(sar.error), 32'd1);

        // Start while busy is ignored; start in the done cycle is accepted.
        a_val = 4'd5;
        sar.start = 1'b1;
        @(posedge clk); #1;
        sar.start = 1'b0;
        @(posedge clk); #1;
        sar.start = 1'b1;
        @(posedge clk); #1;
        sar.start = 1'b0;
        begin
            int guard;
            guard = 0;
            while (!sar.done && guard < 20) begin
                @(posedge clk); #1;
                guard++;
            end
        end
        check("busy_start_done",   32'(sar.done),   32'd1);
        check("busy_start_result", 32'(sar.result), 32'd5);
        check("busy_start_steps",  32'(sar.steps),  32'd4);
        a_val = 4'd8;
        sar.start = 1'b1;
        @(posedge clk); #1;
        sar.start = 1'b0;
        check("restart_busy",  32'(sar.busy),  32'd1);
        check("restart_trial", 32'(sar.trial), 32'd8);
        check("restart_steps", 32'(sar.steps), 32'd0);
        check("restart_found", 32'(sar.found), 32'd0);
        begin
            int guard;
            guard = 0;
            while (!sar.done && guard < 20) begin
                @(posedge clk); #1;
                guard++;
            end
        end
        check("restart_result", 32'(sar.result), 32'd8);
        check("restart_steps_end", 32'(sar.steps), EE ? 32'd1 : 32'd4);
        @(posedge clk); #1;

        // Reset after two probes: outputs clear at once and no done pulse follows.
        a_val = 4'd5;
        sar.start = 1'b1;
        @(posedge clk); #1;
        sar.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy_before", 32'(sar.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(posedge clk); #1;
        check("midrst_done1", 32'(sar.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_done2", 32'(sar.done), 32'd0);
        check("midrst_busy2", 32'(sar.busy), 32'd0);
        do_search(4'd5, to);
        check("post_rst_timeout", 32'(to), 32'd0);
        check("post_rst_result", 32'(sar.result), 32'd5);
        check("post_rst_found",  32'(sar.found),  32'd1);
        check("post_rst_steps",  32'(sar.steps),  32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
